// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the 7-segment receive path
package seg7_pkg;

    // Active-low segment patterns, bit6=a .. bit0=g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_ERR   = 4'hF;

    typedef enum logic {
        ST_ACQ,
        ST_LOCKED
    } state_e;

endpackage

// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - digit update event port
interface seg7_capture_if;
    logic       upd_valid;
    logic       upd_ready;
    logic [2:0] upd_idx;
    logic [3:0] upd_val;

    modport master (
        output upd_valid,
        output upd_idx,
        output upd_val,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_idx,
        input  upd_val,
        output upd_ready
    );
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low segment pattern to digit code
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = CODE_ERR;
        err  = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_ERR;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - sample a multiplexed 7-segment bus into a per-digit register file
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   sel_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_err,
    seg7_capture_if.master          upd,
    output logic                    overrun
);

    localparam int         SW      = NUM_DIGITS + 7;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [SW-1:0] sync1_q, sync1_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [SW-1:0] prev_q, prev_d;
    logic [7:0]    cnt_q, cnt_d;
    state_e        state_q, state_d;

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      err_q, err_d;
    logic                       upd_valid_q, upd_valid_d;
    logic [2:0]                 upd_idx_q, upd_idx_d;
    logic [3:0]                 upd_val_q, upd_val_d;
    logic                       overrun_q, overrun_d;

    logic                  changed;
    logic                  accept;
    logic [NUM_DIGITS-1:0] sel;
    logic [2:0]            zero_cnt;
    logic [2:0]            sel_idx;
    logic [3:0]            cur_code;
    logic                  wr_en;
    logic                  new_event;
    logic [3:0]            dec_code;
    logic                  dec_err;

    seg7_decode u_decode (
        .seg  (samp_q[6:0]),
        .code (dec_code),
        .err  (dec_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter is compared one sample behind, so an accept fires on the edge it reaches CNT_MAX
    always_comb begin
        sync1_d = {sel_in, seg_in};
        samp_d  = sync1_q;
        prev_d  = samp_q;
        changed = (samp_q != prev_q);
        if (changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_ACQ: begin
                if (!changed && cnt_d == CNT_MAX) begin
                    accept  = 1'b1;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (changed) begin
                    state_d = ST_ACQ;
                end
            end
            default: state_d = ST_ACQ;
        endcase
    end

    always_comb begin
        sel      = samp_q[SW-1:7];
        zero_cnt = 3'd0;
        sel_idx  = 3'd0;
        cur_code = CODE_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel[i]) begin
                zero_cnt = zero_cnt + 3'd1;
                sel_idx  = 3'(i);
                cur_code = digits_q[i];
            end
        end
        wr_en     = accept && (zero_cnt == 3'd1);
        new_event = wr_en && (dec_code != cur_code);

        digits_d = digits_q;
        err_d    = err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en && sel_idx == 3'(i)) begin
                digits_d[i] = dec_code;
                err_d[i]    = dec_err;
            end
        end

        upd_valid_d = upd_valid_q;
        upd_idx_d   = upd_idx_q;
        upd_val_d   = upd_val_q;
        overrun_d   = overrun_q;
        if (new_event) begin
            if (upd_valid_q && !upd.upd_ready) begin
                overrun_d = 1'b1;
            end
            upd_valid_d = 1'b1;
            upd_idx_d   = sel_idx;
            upd_val_d   = dec_code;
        end else if (upd_valid_q && upd.upd_ready) begin
            upd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '1;
            samp_q      <= '1;
            prev_q      <= '1;
            cnt_q       <= 8'd0;
            digits_q    <= {NUM_DIGITS{CODE_BLANK}};
            err_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= 3'd0;
            upd_val_q   <= 4'd0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            samp_q      <= samp_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            err_q       <= err_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_val_q   <= upd_val_d;
            overrun_q   <= overrun_d;
        end
    end

    assign digits        = digits_q;
    assign digit_err     = err_q;
    assign upd.upd_valid = upd_valid_q;
    assign upd.upd_idx   = upd_idx_q;
    assign upd.upd_val   = upd_val_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - self-checking bench for seg7_capture
module tb_seg7_capture;

    localparam int STABLE = 4;
    localparam int ND     = 6;
    localparam logic [6:0] PAT [0:10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111111
    };

    logic          clk;
    logic          rst;
    logic [6:0]    seg_p;
    logic [ND-1:0] sel_p;
    logic [23:0]   digits;
    logic [ND-1:0] digit_err;
    logic          overrun;
    logic          ready;

    seg7_capture_if u_if ();
    assign u_if.upd_ready = ready;

    seg7_capture #(.STABLE_CYCLES(STABLE), .NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_p),
        .sel_in    (sel_p),
        .digits    (digits),
        .digit_err (digit_err),
        .upd       (u_if),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what the pins have been, and what the outputs must be as a result
    logic [12:0]    m_d1, m_d2, m_last;
    int             m_run;
    logic [5:0][3:0] m_dig;
    logic [ND-1:0]  m_err;
    logic           m_vld, m_ovr;
    logic [2:0]     m_idx;
    logic [3:0]     m_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] decode(input logic [6:0] p);
        for (int i = 0; i < 11; i++) begin
            if (p == PAT[i]) return (i == 10) ? 4'hE : 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_d1   = '1;
        m_d2   = '1;
        m_last = '1;
        m_run  = 1;
        m_dig  = {6{4'hE}};
        m_err  = '0;
        m_vld  = 1'b0;
        m_ovr  = 1'b0;
        m_idx  = 3'd0;
        m_val  = 4'd0;
    endtask

    // A synchronized value is accepted once it has been seen for exactly STABLE samples in a row
    task automatic model_edge();
        logic [12:0] s;
        int          z;
        int          k;
        logic [3:0]  code;
        logic        ev;
        if (rst) return;
        s    = m_d2;
        m_d2 = m_d1;
        m_d1 = {sel_p, seg_p};
        if (s == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_last = s;
        ev   = 1'b0;
        k    = 0;
        code = 4'd0;
        if (m_run == STABLE) begin
            z = 0;
            for (int i = 0; i < ND; i++) begin
                if (!s[7+i]) begin
                    z++;
                    k = i;
                end
            end
            if (z == 1) begin
                code     = decode(s[6:0]);
                m_err[k] = (code == 4'hF);
                if (code != m_dig[k]) begin
                    m_dig[k] = code;
                    ev       = 1'b1;
                end
            end
        end
        if (ev) begin
            if (m_vld && !ready) m_ovr = 1'b1;
            m_vld = 1'b1;
            m_idx = 3'(k);
            m_val = code;
        end else if (m_vld && ready) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    always @(negedge clk) begin
        chk("digits", digits, m_dig);
        chk("digit_err", digit_err, m_err);
        chk("upd_valid", u_if.upd_valid, m_vld);
        chk("overrun", overrun, m_ovr);
        if (m_vld) begin
            chk("upd_idx", u_if.upd_idx, m_idx);
            chk("upd_val", u_if.upd_val, m_val);
        end
    end

    initial begin
        rst   = 1'b1;
        ready = 1'b1;
        sel_p = '1;
        seg_p = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_digits", digits, 24'hEEEEEE);
        chk("reset_valid", u_if.upd_valid, 0);
        chk("reset_err", digit_err, 0);
        cyc(8);

        // Basic decode and latency
        sel_p = 6'b011111;
        seg_p = PAT[0];
        cyc(5);
        chk("lat_early_valid", u_if.upd_valid, 0);
        chk("lat_early_digits", digits, 24'hEEEEEE);
        cyc(1);
        chk("lat_valid", u_if.upd_valid, 1);
        chk("lat_idx", u_if.upd_idx, 5);
        chk("lat_val", u_if.upd_val, 0);
        chk("lat_digits", digits, 24'h0EEEEE);
        cyc(1);
        chk("pulse_end", u_if.upd_valid, 0);
        cyc(10);
        chk("no_second_event", u_if.upd_valid, 0);

        // Sweep
        for (int v = 0; v < 11; v++) begin
            seg_p = PAT[v];
            cyc(10);
        end
        chk("sweep_blank", digits[23:20], 4'hE);

        // Glitch, then invalid pattern
        seg_p = PAT[0];
        cyc(10);
        seg_p = PAT[3];
        cyc(2);
        seg_p = PAT[0];
        cyc(10);
        chk("glitch_digit", digits[23:20], 4'h0);
        seg_p = 7'b1111110;
        cyc(10);
        chk("invalid_code", digits[23:20], 4'hF);
        chk("invalid_err", digit_err[5], 1);
        seg_p = PAT[1];
        cyc(10);
        chk("err_clear", digit_err[5], 0);
        chk("err_clear_code", digits[23:20], 4'h1);

        // Backpressure
        ready = 1'b0;
        seg_p = PAT[3];
        cyc(10);
        seg_p = PAT[7];
        cyc(10);
        chk("bp_valid", u_if.upd_valid, 1);
        chk("bp_val", u_if.upd_val, 7);
        chk("bp_overrun", overrun, 1);
        ready = 1'b1;
        cyc(1);
        chk("bp_drain", u_if.upd_valid, 0);

        // Select edge cases
        sel_p = 6'b111111;
        seg_p = PAT[2];
        cyc(10);
        sel_p = 6'b001111;
        cyc(10);
        chk("sel_nowrite", digits, 24'h7EEEEE);
        chk("sel_noevent", u_if.upd_valid, 0);

        // Scan all digits
        begin
            int vals [6] = '{2, 4, 6, 8, 9, 3};
            for (int k = 0; k < ND; k++) begin
                sel_p = ~(6'b000001 << k);
                seg_p = PAT[vals[k]];
                cyc(8);
            end
        end
        chk("scan_digits", digits, 24'h398642);

        // Asynchronous mid-cycle reset
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_digits", digits, 24'hEEEEEE);
        chk("async_rst_valid", u_if.upd_valid, 0);
        chk("async_rst_overrun", overrun, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side companion to the team's 7-segment display driver. Samples a multiplexed, active-low segment/select bus (up to 6 digits), filters glitches and multiplex transitions, decodes each stable segment pattern back to a BCD digit code, and keeps a per-digit register file. Each change in a stored digit is also reported as an event on a valid/ready port. The block sits between external display pins (or a driver under test) and logic that needs the displayed value, such as self-check, logging or loopback test.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a pattern is accepted (range 2..255).
- `NUM_DIGITS`, default 6: number of select lines/digits (1..6).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `seg_in` in 7: segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- `sel_in` in NUM_DIGITS: digit selects, active-low; `sel_in[k]`=0 selects digit k.
- `digits` out 4*NUM_DIGITS: stored code of digit k at `[4k+3:4k]`.
- `digit_err` out NUM_DIGITS: bit k set while digit k holds an undecodable pattern.
- `upd_valid` out 1: update event pending.
- `upd_ready` in 1: consumer accepts the event.
- `upd_idx` out 3: digit index of the pending event.
- `upd_val` out 4: new code of the pending event.
- `overrun` out 1: sticky; an event was overwritten before acceptance.

## Operation
- Input path: 2-flop synchronizer on `seg_in` and `sel_in`. All further logic uses the synchronized sample S={sel,seg}.
- Stability counter `stab_cnt`, saturating at STABLE_CYCLES-1:
  - clears to 0 when S differs from the previous S;
  - otherwise increments.
- FSM `ACQ` / `LOCKED`:
  - ACQ: when `stab_cnt` reaches STABLE_CYCLES-1 and S is unchanged, perform the accept action, then go to LOCKED.
  - LOCKED: any change in S returns to ACQ. No further accepts occur while S is unchanged.
- Accept action:
  - Only when `sel` has exactly one zero bit (index k < NUM_DIGITS). Select all-ones or multi-zero: no write, FSM still moves to LOCKED.
  - Decode table (seg → code): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 1111111→4'hE (blank).
  - Any other pattern → 4'hF, and set `digit_err[k]`. `digit_err[k]` clears whenever a decodable pattern is written to k.
  - If the code differs from `digits[k]`: write it and raise an event (idx=k, val=code). If the code is equal: no event.
- Event port (single-entry holding register):
  - `upd_valid` stays high with stable `upd_idx`/`upd_val` until a cycle where `upd_valid & upd_ready`.
  - New event while pending and not being accepted in the same cycle: overwrite idx/val, keep `upd_valid`=1, set `overrun`.
  - New event in the same cycle as an acceptance: load the new event, `upd_valid` stays 1, no overrun.
  - `overrun` clears only on reset.

## Timing
- Reset values:
  - `digits`: all 4'hE
  - `digit_err`: 0
  - `upd_valid`: 0
  - `upd_idx`: 0
  - `upd_val`: 0
  - `overrun`: 0
  - FSM: ACQ
  - `stab_cnt`: 0
  - synchronizers: all-ones (idle bus)
- Latency: pins stable before edge 0 → `digits`/`upd_valid` updated after edge STABLE_CYCLES+1. That is 2 synchronizer edges, then STABLE_CYCLES-1 edges of counting; registered outputs.
- Glitches: any pin change lasting fewer than STABLE_CYCLES+? cycles after synchronization, i.e. fewer than STABLE_CYCLES synchronized cycles, produces no write.
- `upd_ready` is sampled combinationally into the holding-register update; there is no combinational path from `upd_ready` to any output.
- `rst` asserted mid-acquisition aborts immediately. Outputs return to reset values asynchronously.

## Structure
- Shared package `seg7_pkg`:
  - active-low pattern constants `SEG_0`..`SEG_9`, `SEG_BLANK`;
  - codes `CODE_BLANK`=4'hE, `CODE_ERR`=4'hF;
  - FSM state enum.
- One sub-module `seg7_decode`: combinational pattern → {code, err}, reusable by other receive-side logic.
- Synchronizer, stability counter, FSM, register file and event holding register stay in the top module.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `digits`=24'hEEEEEE, `upd_valid`=0, `overrun`=0 before the next edge.
- Basic decode: `sel_in`=011111, `seg_in`=0000001 held, `upd_ready`=1 → after STABLE_CYCLES+2 edges `digits[23:20]`=0 and a one-cycle `upd_valid` pulse with idx=5, val=0. Holding the inputs longer produces no second event.
- Sweep: step through patterns 0..9 on digit 5, each held 10 cycles → events with val 0..9 in order. Then 1111111 → val 4'hE.
- Glitch/invalid: `seg_in`=0000110 held only 2 cycles inside a 0000001 stream → no event. Then `seg_in`=1111110 held → `digits[23:20]`=4'hF and `digit_err[5]`=1. Then 1001111 → `digit_err[5]`=0.
- Backpressure: `upd_ready`=0, accept 3 then 7 on digit 5 → `upd_valid`=1, `upd_val`=7, `overrun`=1. Then `upd_ready`=1 for one cycle → `upd_valid`=0.
- Select edge cases: `sel_in`=111111 and 001111 held with a valid pattern → no writes, no events. Scanning digits 0..5 with distinct values → each field of `digits` correct.
